// File: rtl/instruction_fetch_unit_pkg.sv
// Shared IF/ID definitions: bubble encoding, reset PC, fetch FSM encoding and the
// IF/ID record layout that decode also consumes.
package rv_pipeline_defs;

   localparam int XLEN          = 32;
   localparam int IF_ID_PC_W    = XLEN;
   localparam int IF_ID_INSTR_W = 32;

   localparam logic [XLEN-1:0]          DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam logic [IF_ID_INSTR_W-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      NORMAL  = 1'b0,
      PENDING = 1'b1
   } fetch_state_e;

   typedef enum logic [1:0] {
      IFID_HOLD   = 2'd0,
      IFID_LOAD   = 2'd1,
      IFID_BUBBLE = 2'd2
   } ifid_op_e;

   typedef struct packed {
      logic [IF_ID_PC_W-1:0]    pc;
      logic [IF_ID_PC_W-1:0]    pc_plus4;
      logic [IF_ID_INSTR_W-1:0] instr;
      logic                     valid;
   } if_id_t;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus to the instruction cache: address out, word and busywait back.
interface instruction_fetch_unit_if;
   logic [31:0] ICACHE_ADDRESS;
   logic [31:0] ICACHE_READDATA;
   logic        ICACHE_BUSYWAIT;

   modport master (output ICACHE_ADDRESS, input ICACHE_READDATA, input ICACHE_BUSYWAIT);
   modport slave  (input ICACHE_ADDRESS, output ICACHE_READDATA, output ICACHE_BUSYWAIT);
endinterface

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register with load / hold / bubble controls.
module if_id_register
   import rv_pipeline_defs::*;
#(
   parameter logic [IF_ID_INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  ifid_op_e                 op_i,
   input  logic [IF_ID_PC_W-1:0]    pc_i,
   input  logic [IF_ID_INSTR_W-1:0] instr_i,
   output if_id_t                   if_id_o
);

   if_id_t ifid_q, ifid_d;

   // A bubble keeps the PC fields so the last fetched address stays visible to debug.
   always_comb begin
      ifid_d = ifid_q;
      unique case (op_i)
         IFID_LOAD: begin
            ifid_d.pc       = pc_i;
            ifid_d.pc_plus4 = pc_i + 32'd4;
            ifid_d.instr    = instr_i;
            ifid_d.valid    = 1'b1;
         end
         IFID_BUBBLE: begin
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ifid_q.pc       <= '0;
         ifid_q.pc_plus4 <= '0;
         ifid_q.instr    <= NOP_INSTR;
         ifid_q.valid    <= 1'b0;
      end else begin
         ifid_q <= ifid_d;
      end
   end

   assign if_id_o = ifid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, drives the I-cache, handles stalls and EX redirects
// (including redirects that land during a miss) and feeds the IF/ID register.
module instruction_fetch_unit
   import rv_pipeline_defs::*;
#(
   parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INSTR   = DEFAULT_NOP_INSTR,
   parameter int          STALL_CNT_W = 16
) (
   input  logic                    CLK,
   input  logic                    RESET,
   instruction_fetch_unit_if.master icache,
   input  logic                    BRANCH_TAKEN,
   input  logic [31:0]             BRANCH_TARGET,
   input  logic                    STALL,
   output logic [31:0]             IF_ID_PC,
   output logic [31:0]             IF_ID_PC_PLUS4,
   output logic [31:0]             IF_ID_INSTR,
   output logic                    IF_ID_VALID,
   output logic                    REDIRECT_PENDING,
   output logic [STALL_CNT_W-1:0]  MISS_STALL_CYCLES
);

   fetch_state_e           state_q, state_d;
   logic [31:0]            pc_q, pc_d;
   logic [31:0]            pend_tgt_q, pend_tgt_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [31:0]            br_tgt;
   logic                   busy;
   ifid_op_e               ifid_op;
   if_id_t                 ifid;

   assign busy                  = icache.ICACHE_BUSYWAIT;
   assign br_tgt                = align_word(BRANCH_TARGET);
   assign icache.ICACHE_ADDRESS = pc_q;

   // The address must stay put while the cache refills, so a redirect seen
   // during a miss is parked and only applied once BUSYWAIT drops.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_tgt_d = pend_tgt_q;
      ifid_op    = IFID_HOLD;
      if (BRANCH_TAKEN && !busy) begin
         pc_d       = br_tgt;
         pend_tgt_d = '0;
         state_d    = NORMAL;
         ifid_op    = IFID_BUBBLE;
      end else if (BRANCH_TAKEN) begin
         pend_tgt_d = br_tgt;
         state_d    = PENDING;
         ifid_op    = IFID_BUBBLE;
      end else if (state_q == PENDING && !busy) begin
         pc_d    = pend_tgt_q;
         state_d = NORMAL;
         ifid_op = IFID_BUBBLE;
      end else if (busy) begin
         ifid_op = STALL ? IFID_HOLD : IFID_BUBBLE;
      end else if (!STALL) begin
         pc_d    = pc_q + 32'd4;
         ifid_op = IFID_LOAD;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (busy && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= NORMAL;
         pc_q        <= RESET_PC;
         pend_tgt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_tgt_q  <= pend_tgt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   if_id_register #(.NOP_INSTR(NOP_INSTR)) u_if_id (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .op_i    (ifid_op),
      .pc_i    (pc_q),
      .instr_i (icache.ICACHE_READDATA),
      .if_id_o (ifid)
   );

   assign IF_ID_PC          = ifid.pc;
   assign IF_ID_PC_PLUS4    = ifid.pc_plus4;
   assign IF_ID_INSTR       = ifid.instr;
   assign IF_ID_VALID       = ifid.valid;
   assign REDIRECT_PENDING  = (state_q == PENDING);
   assign MISS_STALL_CYCLES = stall_cnt_q;

endmodule
